// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_pkg : shared types and constants for the 4x4 keypad scanner |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
package keypad_pkg;

  localparam int SCAN_DIV_DEFAULT        = 100000;
  localparam int DEBOUNCE_FRAMES_DEFAULT = 4;
  localparam int REPEAT_FRAMES           = 32;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FR_NONE   = 2'd0,
    FR_SINGLE = 2'd1,
    FR_MULTI  = 2'd2
  } frame_cls_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_sync : parameterized-width two-flop synchronizer            |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module keypad_sync #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scan : 4x4 matrix keypad scanner with frame debounce        |
// |   Optional KEYPAD_REPEAT_EN: auto-repeat key_valid while held.     |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = SCAN_DIV_DEFAULT,
  parameter int DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int c_DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_FCNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_FCNT_W-1:0] c_FCNT_MAX = c_FCNT_W'(DEBOUNCE_FRAMES);
  localparam logic [c_FCNT_W-1:0] c_FCNT_ONE = c_FCNT_W'(1);

  logic [3:0]          w_rows_n;
  logic [c_DIV_W-1:0]  div_q;
  logic [1:0]          col_q;
  logic                w_tick, w_frame_done;
  logic [3:0]          w_act;
  logic [2:0]          w_nact, w_sum;
  logic [1:0]          w_ridx, w_slot_cnt, w_cnt_full;
  key_code_t           w_code_full;
  logic                w_hit_full;
  frame_cls_e          w_cls;
  logic [1:0]          acc_cnt_q;
  key_code_t           acc_code_q;
  logic                acc_hit_q;
  state_e              state_q, state_d;
  logic [c_FCNT_W-1:0] fcnt_q, fcnt_d, w_fcnt_inc;
  key_code_t           cand_q, cand_d, key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic                w_accept, w_release, w_repeat;

  keypad_sync #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d_i (row_n),
    .q_o (w_rows_n)
  );

  assign w_tick       = (div_q == c_DIV_LAST);
  assign w_frame_done = w_tick && (col_q == 2'd3);
  assign col_n        = ~(4'b0001 << col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      col_q <= '0;
    end else if (w_tick) begin
      div_q <= '0;
      col_q <= col_q + 2'd1;
    end else begin
      div_q <= div_q + c_DIV_W'(1);
    end
  end

  // Per-slot row sample folded into a running frame summary (count saturates at 2).
  assign w_act = ~w_rows_n;
  assign w_nact = popcount4(w_act);

  always_comb begin
    w_ridx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (w_act[r]) w_ridx = 2'(r);
    end
  end

  assign w_slot_cnt  = (w_nact >= 3'd2) ? 2'd2 : w_nact[1:0];
  assign w_sum       = {1'b0, acc_cnt_q} + {1'b0, w_slot_cnt};
  assign w_cnt_full  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
  assign w_code_full = (acc_cnt_q == 2'd0 && w_nact == 3'd1) ? {w_ridx, col_q} : acc_code_q;
  assign w_hit_full  = acc_hit_q | ((col_q == cand_q[1:0]) && w_act[cand_q[3:2]]);
  assign w_cls       = (w_cnt_full == 2'd0) ? FR_NONE :
                       (w_cnt_full == 2'd1) ? FR_SINGLE : FR_MULTI;

  always_ff @(posedge clk) begin
    if (rst || w_frame_done) begin
      acc_cnt_q  <= '0;
      acc_code_q <= '0;
      acc_hit_q  <= 1'b0;
    end else if (w_tick) begin
      acc_cnt_q  <= w_cnt_full;
      acc_code_q <= w_code_full;
      acc_hit_q  <= w_hit_full;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fcnt_q      <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign w_fcnt_inc = (fcnt_q == c_FCNT_MAX) ? fcnt_q : fcnt_q + c_FCNT_ONE;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    cand_d  = cand_q;
    if (w_frame_done) begin
      case (state_q)
        ST_IDLE: begin
          fcnt_d = '0;
          if (w_cls == FR_SINGLE) begin
            cand_d = w_code_full;
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = ST_PRESSED;
            end else begin
              state_d = ST_CONFIRM;
              fcnt_d  = c_FCNT_ONE;
            end
          end
        end
        ST_CONFIRM: begin
          if (w_cls == FR_SINGLE && w_code_full == cand_q) begin
            if (w_fcnt_inc == c_FCNT_MAX) begin
              state_d = ST_PRESSED;
              fcnt_d  = '0;
            end else begin
              fcnt_d = w_fcnt_inc;
            end
          end else begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
          end
        end
        ST_PRESSED: begin
          if (w_cls == FR_NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
              fcnt_d  = c_FCNT_ONE;
            end
          end
        end
        ST_RELEASE: begin
          if (w_cls == FR_NONE) begin
            if (w_fcnt_inc == c_FCNT_MAX) begin
              state_d = ST_IDLE;
              fcnt_d  = '0;
            end else begin
              fcnt_d = w_fcnt_inc;
            end
          end else if (w_hit_full) begin
            state_d = ST_PRESSED;
            fcnt_d  = '0;
          end else begin
            // Another key alone interrupts the release run without re-accepting.
            fcnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_accept    = w_frame_done && (state_d == ST_PRESSED) &&
                  (state_q == ST_IDLE || state_q == ST_CONFIRM);
    w_release   = w_frame_done && (state_d == ST_IDLE) &&
                  (state_q == ST_PRESSED || state_q == ST_RELEASE);
    key_valid_d = w_accept | w_repeat;
    key_code_d  = w_accept ? cand_d : key_code_q;
    key_held_d  = (key_held_q | w_accept) & ~w_release;
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int c_REP_W = $clog2(REPEAT_FRAMES);
  logic [c_REP_W-1:0] rep_q, rep_d;

  always_comb begin
    rep_d    = rep_q;
    w_repeat = 1'b0;
    if (state_q != ST_PRESSED || state_d != ST_PRESSED) begin
      rep_d = '0;
    end else if (w_frame_done) begin
      if (!w_hit_full) begin
        rep_d = '0;
      end else if (rep_q == c_REP_W'(REPEAT_FRAMES - 1)) begin
        rep_d    = '0;
        w_repeat = 1'b1;
      end else begin
        rep_d = rep_q + c_REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  assign w_repeat = 1'b0;
`endif

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`default_nettype none
// Testbench for keypad_scan: frame-level keypad model driving row_n from col_n,
// directed scenarios plus randomized key sequences against a behavioural model.
module tb_keypad_scan;

  localparam int SCAN_DIV = 8;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP = 32;
`else
  localparam int REP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col_n, row_n, key_code;
  logic        key_valid, key_held;
  logic [15:0] keys = '0;
  logic [15:0] seq [$];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit         m_held, m_in_rel;
  int         m_run, m_rel, m_rep;
  logic [3:0] m_cand, m_code;

  // Observations of the last sequence
  bit           o_pulse, o_held;
  int           o_stray, o_colerr;
  logic [127:0] o_pmask, e_pmask, o_hmask, e_hmask;

  always #5 clk = ~clk;

  // Pressed key (row r, col c) shorts row r to column c while c is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  function automatic logic [15:0] key(input int k);
    return 16'(1) << k;
  endfunction

  task automatic model_reset();
    m_held = 0; m_in_rel = 0; m_run = 0; m_rel = 0; m_rep = 0;
    m_cand = '0; m_code = '0;
  endtask

  task automatic model_frame(input logic [15:0] mask, output bit pulse);
    int n;
    logic [3:0] idx;
    pulse = 0;
    n = $countones(mask);
    idx = '0;
    for (int k = 0; k < 16; k++) if (mask[k]) idx = 4'(k);
    if (!m_held) begin
      if (n == 1) begin
        if (m_run == 0) begin m_cand = idx; m_run = 1; end
        else if (idx == m_cand) m_run++;
        else m_run = 0;
        if (m_run >= DEB) begin
          pulse = 1; m_held = 1; m_code = m_cand; m_run = 0; m_rep = 0; m_in_rel = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (n == 0) begin
      m_rel = m_in_rel ? m_rel + 1 : 1;
      m_in_rel = 1; m_rep = 0;
      if (m_rel >= DEB) begin m_held = 0; m_in_rel = 0; m_rel = 0; end
    end else if (mask[m_cand]) begin
      if (m_in_rel) begin m_in_rel = 0; m_rel = 0; m_rep = 0; end
      else if (REP > 0) begin
        m_rep++;
        if (m_rep == REP) begin pulse = 1; m_rep = 0; end
      end
    end else begin
      if (m_in_rel) m_rel = 0; else m_rep = 0;
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    model_reset();
  endtask

  task automatic drive_frame(input logic [15:0] mask);
    logic [3:0] exp_col;
    keys = mask;
    o_pulse = 0;
    o_held = 0;
    for (int j = 1; j <= FRAME; j++) begin
      @(posedge clk);
      #1;
      exp_col = 4'b0001 << ((j / SCAN_DIV) % 4);
      if (col_n !== ~exp_col) o_colerr++;
      if (key_valid === 1'b1) begin
        if (j == FRAME) o_pulse = 1; else o_stray++;
      end else if (key_valid !== 1'b0) begin
        o_stray++;
      end
      if (j == FRAME) o_held = key_held;
    end
  endtask

  task automatic push(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) seq.push_back(m);
  endtask

  task automatic run_seq();
    bit ep;
    o_pmask = '0; e_pmask = '0; o_hmask = '0; e_hmask = '0;
    o_stray = 0; o_colerr = 0;
    for (int f = 0; f < seq.size(); f++) begin
      drive_frame(seq[f]);
      model_frame(seq[f], ep);
      o_pmask[f] = o_pulse; e_pmask[f] = ep;
      o_hmask[f] = o_held;  e_hmask[f] = m_held;
    end
    seq.delete();
  endtask

  task automatic test_reset();
    apply_reset(2);
    n_tests++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL reset_col_n: got %b, want 1110", col_n); end
    n_tests++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b, want 0", key_valid); end
    n_tests++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b, want 0", key_held); end
    n_tests++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_key_code: got %h, want 0", key_code); end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    push(16'h0, 3);
    run_seq();
    n_tests++; if (o_colerr != 0) begin n_fail++; $display("FAIL idle_col_seq: got %0d bad cycles, want 0", o_colerr); end
    n_tests++; if (o_pmask != '0 || o_stray != 0) begin n_fail++; $display("FAIL idle_no_valid: got pulses %h stray %0d, want none", o_pmask, o_stray); end
  endtask

  task automatic test_key6();
    push(key(6), 5); push(16'h0, 3);
    run_seq();
    n_tests++; if (o_pmask !== 128'h4) begin n_fail++; $display("FAIL key6_pulse: got %h, want 4", o_pmask); end
    n_tests++; if (o_stray != 0) begin n_fail++; $display("FAIL key6_one_cycle: got %0d stray, want 0", o_stray); end
    n_tests++; if (o_hmask !== 128'h7C) begin n_fail++; $display("FAIL key6_held: got %h, want 7c", o_hmask); end
    n_tests++; if (key_code !== 4'h6) begin n_fail++; $display("FAIL key6_code: got %h, want 6", key_code); end
  endtask

  task automatic test_glitch();
    push(key(6), 2); push(16'h0, 1); push(key(6), 3); push(16'h0, 3);
    run_seq();
    n_tests++; if (o_pmask !== 128'h20 || o_stray != 0) begin n_fail++; $display("FAIL glitch_pulse: got %h stray %0d, want 20", o_pmask, o_stray); end
    n_tests++; if (o_hmask !== 128'hE0) begin n_fail++; $display("FAIL glitch_held: got %h, want e0", o_hmask); end
  endtask

  task automatic test_multi();
    push(key(0) | key(5), 4); push(key(5), 3); push(key(0) | key(5), 3); push(16'h0, 3);
    run_seq();
    n_tests++; if (o_pmask !== 128'h40 || o_stray != 0) begin n_fail++; $display("FAIL multi_pulse: got %h stray %0d, want 40", o_pmask, o_stray); end
    n_tests++; if (o_hmask !== 128'hFC0) begin n_fail++; $display("FAIL multi_held: got %h, want fc0", o_hmask); end
    n_tests++; if (key_code !== 4'h5) begin n_fail++; $display("FAIL multi_code: got %h, want 5", key_code); end
  endtask

  task automatic test_reset_midpress();
    push(key(6), 3);
    run_seq();
    n_tests++; if (o_pmask !== 128'h4 || key_held !== 1'b1) begin n_fail++; $display("FAIL rmp_accept: got %h held %b, want 4 held 1", o_pmask, key_held); end
    repeat (13) @(posedge clk);
    apply_reset(1);
    n_tests++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rmp_held_drop: got %b, want 0", key_held); end
    n_tests++; if (col_n !== 4'b1110) begin n_fail++; $display("FAIL rmp_col_n: got %b, want 1110", col_n); end
    rst = 1'b0;
    push(key(6), 3); push(16'h0, 3);
    run_seq();
    n_tests++; if (o_pmask !== 128'h4 || o_stray != 0) begin n_fail++; $display("FAIL rmp_repulse: got %h stray %0d, want 4", o_pmask, o_stray); end
    n_tests++; if (o_hmask !== 128'h1C) begin n_fail++; $display("FAIL rmp_held: got %h, want 1c", o_hmask); end
  endtask

  task automatic test_repeat();
    logic [127:0] exp_p, exp_h;
    exp_p = '0;
    exp_p[2] = 1'b1;
`ifdef KEYPAD_REPEAT_EN
    exp_p[34] = 1'b1;
    exp_p[66] = 1'b1;
`endif
    exp_h = '0;
    for (int f = 2; f < 72; f++) exp_h[f] = 1'b1;
    push(key(10), 70); push(16'h0, 3);
    run_seq();
    n_tests++; if (o_pmask !== exp_p || o_stray != 0) begin n_fail++; $display("FAIL repeat_pulses: got %h stray %0d, want %h", o_pmask, o_stray, exp_p); end
    n_tests++; if (o_hmask !== exp_h) begin n_fail++; $display("FAIL repeat_held: got %h, want %h", o_hmask, exp_h); end
    n_tests++; if (key_code !== 4'hA) begin n_fail++; $display("FAIL repeat_code: got %h, want a", key_code); end
  endtask

  task automatic test_random();
    int kind;
    logic [15:0] last_single;
    for (int b = 0; b < 2; b++) begin
      last_single = key(6);
      while (seq.size() < 110) begin
        kind = $urandom_range(0, 8);
        if (kind <= 2) push(16'h0, $urandom_range(1, 5));
        else if (kind <= 5) begin
          last_single = key($urandom_range(0, 15));
          push(last_single, $urandom_range(1, 5));
        end else if (kind <= 7) push(key($urandom_range(0, 15)) | key($urandom_range(0, 15)), $urandom_range(1, 5));
        else push(last_single | key($urandom_range(0, 15)), $urandom_range(1, 5));
      end
      push(16'h0, DEB);
      run_seq();
      n_tests++; if (o_pmask !== e_pmask) begin n_fail++; $display("FAIL rand_pulses[%0d]: got %h, want %h", b, o_pmask, e_pmask); end
      n_tests++; if (o_hmask !== e_hmask) begin n_fail++; $display("FAIL rand_held[%0d]: got %h, want %h", b, o_hmask, e_hmask); end
      n_tests++; if (o_stray != 0) begin n_fail++; $display("FAIL rand_one_cycle[%0d]: got %0d stray, want 0", b, o_stray); end
      n_tests++; if (o_colerr != 0) begin n_fail++; $display("FAIL rand_col_seq[%0d]: got %0d bad cycles, want 0", b, o_colerr); end
      n_tests++; if (key_code !== m_code) begin n_fail++; $display("FAIL rand_code[%0d]: got %h, want %h", b, key_code, m_code); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_key6();
    test_glitch();
    test_multi();
    test_reset_midpress();
    test_repeat();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clock cycles each column stays driven (1 ms at 100 MHz); legal minimum 4.
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4, meaning consecutive identical full-matrix frames required to accept a press or a release; legal minimum 1.
REQ-003 SHALL have port clk, input, 1, system clock (CLK100MHZ on board).
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port col_n, output, 4, active-low column drive, exactly one bit low at all times.
REQ-006 SHALL have port row_n, input, 4, active-low row sense (pulled up externally), asynchronous.
REQ-007 SHALL have port key_code, output, 4, accepted key index = {row_idx[1:0], col_idx[1:0]}.
REQ-008 SHALL have port key_valid, output, 1, one-cycle pulse on accepted press.
REQ-009 SHALL have port key_held, output, 1, high from accepted press until accepted release.

Function
REQ-010 SHALL pass row_n through a 2-flop synchronizer before any use.
REQ-011 SHALL drive columns in order col0, col1, col2, col3, then wrap to col0; each slot lasts SCAN_DIV cycles.
REQ-012 SHALL sample synchronized rows only on the last cycle of each slot (slot tick).
REQ-013 SHALL classify each frame (4 slots) at the col3 tick as NONE (0 active row bits), SINGLE(code) (exactly 1), or MULTI (2 or more).
REQ-014 SHALL implement FSM states IDLE, CONFIRM, PRESSED, RELEASE with a frame counter fcnt.
REQ-015 IDLE: SINGLE(c) -> cand=c, fcnt=1, and CONFIRM; if DEBOUNCE_FRAMES==1, go straight to PRESSED instead.
REQ-016 CONFIRM: SINGLE(cand) -> fcnt+1, and on reaching DEBOUNCE_FRAMES go to PRESSED; any other result -> IDLE, fcnt=0.
REQ-017 On entering PRESSED, the block SHALL load key_code=cand, pulse key_valid high for exactly one cycle (cycle after the deciding tick), and set key_held=1.
REQ-018 PRESSED: NONE -> RELEASE, fcnt=1; SINGLE(cand) or MULTI/other-key -> stay (no rollover; a second key is ignored).
REQ-019 RELEASE: NONE -> fcnt+1, and on reaching DEBOUNCE_FRAMES go to IDLE with key_held=0; any frame containing cand -> PRESSED without a new key_valid pulse.
REQ-020 key_code SHALL hold its last accepted value through IDLE.
REQ-021 fcnt SHALL saturate at DEBOUNCE_FRAMES and SHALL be wide enough for it ($clog2(DEBOUNCE_FRAMES+1)).

Reset
REQ-022 rst SHALL force col_n=4'b1110, slot counter=0, column index=0, synchronizer=4'hF, state=IDLE, fcnt=0, cand=0, key_code=0, key_valid=0, key_held=0.
REQ-023 rst asserted mid-press SHALL drop key_held the next cycle; no key_valid pulse SHALL follow reset until a full debounce completes.

Configuration
REQ-024 Macro KEYPAD_REPEAT_EN: when defined, in PRESSED key_valid SHALL re-pulse every REPEAT_FRAMES (package constant, 32) consecutive frames containing cand; when undefined, there is exactly one pulse per press.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum, the key_code typedef (logic [3:0]), REPEAT_FRAMES, and default values for SCAN_DIV and DEBOUNCE_FRAMES.
REQ-026 Sub-module keypad_sync (parameterized-width 2-flop synchronizer) SHALL be instantiated for row_n.

Verification (SCAN_DIV=8, DEBOUNCE_FRAMES=3; frame = 32 cycles)
REQ-027 Reset then idle rows=4'hF -> col_n cycles 1110,1101,1011,0111 every 8 cycles; key_valid never asserts.
REQ-028 Hold row1 low only while col2 is driven (key 6) for 5 frames -> exactly one key_valid pulse after the 3rd frame, key_code=4'h6, key_held=1; release for 3 frames -> key_held=0.
REQ-029 Key 6 present 2 frames, absent 1 frame, present 3 frames -> single pulse after the 6th frame, none earlier.
REQ-030 Keys 0 and 5 pressed together -> MULTI every frame, no pulse; press key 5 first, accept it, then add key 0 -> key_code stays 5 and no second pulse.
REQ-031 Assert rst for 1 cycle while key_held=1 -> key_held=0 and col_n=1110 next cycle; key still pressed -> new pulse after 3 further frames.
REQ-032 With KEYPAD_REPEAT_EN defined, hold key A for 70 frames -> pulses at frames 3, 35 and 67 with key_code=4'hA.
